// File: rtl/control_ring_stop.sv
// Control-ring stop: forwards transit, ejects packets addressed to this node, and injects queued local packets.
// Latency: ring_in->ring_out/local_rx 1 cycle; local_tx change->ring_out 2 cycles (capture, then inject).
// Backpressure: transit always wins the slot; local packets wait in the FIFO, and a capture into a full FIFO is dropped.
// Optional: define CTRL_RING_STATS_EN to add saturating stat_fwd/stat_inj/stat_ej/stat_drop counters.
module control_ring_stop #(
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] node_id,
  input  logic [31:0] ring_in,
  output logic [31:0] ring_out,
  input  logic [31:0] local_tx,
  output logic [31:0] local_rx,
  output logic        local_rx_valid,
  output logic        fifo_full,
  output logic        drop_pulse
`ifdef CTRL_RING_STATS_EN
  ,
  output logic [15:0] stat_fwd,
  output logic [15:0] stat_inj,
  output logic [15:0] stat_ej,
  output logic [15:0] stat_drop
`endif
);

  localparam int          AW   = $clog2(FIFO_DEPTH);
  localparam logic [31:0] IDLE = 32'hFF00_0000;

  logic [31:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [31:0] prev_tx_q;
  logic [31:0] ring_out_q, local_rx_q;
  logic        local_rx_valid_q, drop_q;

  logic [ID_W-1:0] my_id, in_dest, in_src;
  logic            dest_idle, eject, ret, fwd;
  logic            fifo_empty, fifo_full_w;
  logic            capture, pop, push, overflow;
  logic            unused_node_id;

  // Only the low ID_W bits of node_id identify the node.
  assign unused_node_id = ^node_id[15:ID_W];

  // Slot decision on the incoming packet, in priority order: eject, return-removal, forward, free.
  always_comb begin
    my_id     = node_id[ID_W-1:0];
    in_dest   = ring_in[24 +: ID_W];
    in_src    = ring_in[16 +: ID_W];
    dest_idle = (ring_in[31:24] == 8'hFF);
    eject     = (in_dest == my_id);
    ret       = !eject && (in_src == my_id);
    fwd       = !eject && !ret && !dest_idle;

    fifo_empty  = (wr_ptr_q == rd_ptr_q);
    fifo_full_w = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A free slot takes the FIFO head; a pop in the same cycle makes room for a new capture.
    pop      = !fwd && !fifo_empty;
    capture  = (local_tx != prev_tx_q) && (local_tx[31:24] != 8'hFF);
    push     = capture && (!fifo_full_w || pop);
    overflow = capture && fifo_full_w && !pop;
  end

  // Ring slot, local delivery, FIFO pointers and change-detect register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ring_out_q       <= IDLE;
      local_rx_q       <= IDLE;
      local_rx_valid_q <= 1'b0;
      drop_q           <= 1'b0;
      prev_tx_q        <= IDLE;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
    end else begin
      prev_tx_q        <= local_tx;
      local_rx_valid_q <= eject;
      drop_q           <= overflow || ret;
      if (eject) local_rx_q <= ring_in;
      if (fwd)       ring_out_q <= ring_in;
      else if (pop)  ring_out_q <= fifo_mem_q[rd_ptr_q[AW-1:0]];
      else           ring_out_q <= IDLE;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  end

  // FIFO storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= local_tx;
  end

  assign ring_out       = ring_out_q;
  assign local_rx       = local_rx_q;
  assign local_rx_valid = local_rx_valid_q;
  assign drop_pulse     = drop_q;
  assign fifo_full      = fifo_full_w;

`ifdef CTRL_RING_STATS_EN
  logic [15:0] stat_fwd_q, stat_inj_q, stat_ej_q, stat_drop_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  // Saturating event counters, one increment per cycle at most.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fwd_q  <= '0;
      stat_inj_q  <= '0;
      stat_ej_q   <= '0;
      stat_drop_q <= '0;
    end else begin
      stat_fwd_q  <= sat_inc(stat_fwd_q, fwd);
      stat_inj_q  <= sat_inc(stat_inj_q, pop);
      stat_ej_q   <= sat_inc(stat_ej_q, eject);
      stat_drop_q <= sat_inc(stat_drop_q, overflow || ret);
    end
  end

  assign stat_fwd  = stat_fwd_q;
  assign stat_inj  = stat_inj_q;
  assign stat_ej   = stat_ej_q;
  assign stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_control_ring_stop.sv
// Bench for control_ring_stop: cycle vectors with a scoreboard queue of expected outputs.
// Inputs driven on the falling edge; outputs compared 1 time unit after the rising edge.
// Node id 16'hAB03 so only the low byte identifies the node.
module tb_control_ring_stop;

  localparam logic [31:0] IDLE = 32'hFF00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] node_id;
  logic [31:0] ring_in, ring_out, local_tx, local_rx;
  logic        local_rx_valid, fifo_full, drop_pulse;
`ifdef CTRL_RING_STATS_EN
  logic [15:0] stat_fwd, stat_inj, stat_ej, stat_drop;
`endif

  control_ring_stop #(.FIFO_DEPTH(4), .ID_W(8)) dut (
    .clk(clk), .rst(rst), .node_id(node_id),
    .ring_in(ring_in), .ring_out(ring_out),
    .local_tx(local_tx), .local_rx(local_rx), .local_rx_valid(local_rx_valid),
    .fifo_full(fifo_full), .drop_pulse(drop_pulse)
`ifdef CTRL_RING_STATS_EN
    , .stat_fwd(stat_fwd), .stat_inj(stat_inj), .stat_ej(stat_ej), .stat_drop(stat_drop)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] ri;
    logic [31:0] tx;
    logic [31:0] out;
    logic [31:0] rx;
    logic        rxv;
    logic        full;
    logic        drop;
  } vec_t;

  vec_t sb_q[$];
  vec_t vecs[16];
  int   n_vec;
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(logic r, logic [31:0] ri, logic [31:0] tx, logic [31:0] out,
                              logic [31:0] rx, logic rxv, logic full, logic drop);
    vec_t v;
    v.rst = r; v.ri = ri; v.tx = tx; v.out = out;
    v.rx = rx; v.rxv = rxv; v.full = full; v.drop = drop;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    rst = v.rst; ring_in = v.ri; local_tx = v.tx;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("ring_out",       idx, ring_out,              e.out);
    chk("local_rx",       idx, local_rx,              e.rx);
    chk("local_rx_valid", idx, {31'd0, local_rx_valid}, {31'd0, e.rxv});
    chk("fifo_full",      idx, {31'd0, fifo_full},    {31'd0, e.full});
    chk("drop_pulse",     idx, {31'd0, drop_pulse},   {31'd0, e.drop});
  endtask

  logic [31:0] rxl;
  logic [31:0] tr;

  initial begin
    rst = 1'b1; node_id = 16'hAB03; ring_in = IDLE; local_tx = IDLE;

    // Reset, eject, forward, inject latency, return-removal, eject+inject, no re-capture.
    n_vec = 0;
    vecs[n_vec++] = mk(1, 32'h0305_1234, IDLE,         IDLE,         IDLE,         0, 0, 0);
    vecs[n_vec++] = mk(1, 32'h0305_1234, IDLE,         IDLE,         IDLE,         0, 0, 0);
    vecs[n_vec++] = mk(0, 32'h0305_ABCD, IDLE,         IDLE,         32'h0305_ABCD, 1, 0, 0);
    vecs[n_vec++] = mk(0, 32'h0702_0001, IDLE,         32'h0702_0001, 32'h0305_ABCD, 0, 0, 0);
    vecs[n_vec++] = mk(0, IDLE,         32'h0603_00AA, IDLE,         32'h0305_ABCD, 0, 0, 0);
    vecs[n_vec++] = mk(0, IDLE,         32'h0603_00AA, 32'h0603_00AA, 32'h0305_ABCD, 0, 0, 0);
    vecs[n_vec++] = mk(0, 32'h0603_00AA, 32'h0603_00AA, IDLE,         32'h0305_ABCD, 0, 0, 1);
    vecs[n_vec++] = mk(0, IDLE,         32'h0603_00AA, IDLE,         32'h0305_ABCD, 0, 0, 0);
    vecs[n_vec++] = mk(0, 32'h0509_0000, 32'h0604_0011, 32'h0509_0000, 32'h0305_ABCD, 0, 0, 0);
    vecs[n_vec++] = mk(0, 32'h0301_0009, 32'h0604_0011, 32'h0604_0011, 32'h0301_0009, 1, 0, 0);
    vecs[n_vec++] = mk(0, IDLE,         32'h0604_0011, IDLE,         32'h0301_0009, 0, 0, 0);
    vecs[n_vec++] = mk(0, IDLE,         IDLE,         IDLE,         32'h0301_0009, 0, 0, 0);
    vecs[n_vec++] = mk(0, IDLE,         IDLE,         IDLE,         32'h0301_0009, 0, 0, 0);
    vecs[n_vec++] = mk(0, 32'h0303_5555, IDLE,         IDLE,         32'h0303_5555, 1, 0, 0);
    vecs[n_vec++] = mk(0, IDLE,         IDLE,         IDLE,         32'h0303_5555, 0, 0, 0);
    for (int i = 0; i < n_vec; i++) step(vecs[i], i);

    // Fill the FIFO behind continuous transit, overflow on the fifth capture.
    rxl = 32'h0303_5555;
    for (int k = 1; k <= 5; k++) begin
      tr = 32'h0500_0000 | k;
      step(mk(0, tr, 32'h0601_0000 | k, tr, rxl, 0, (k >= 4), (k == 5)), 100 + k);
    end
    step(mk(0, 32'h0500_0010, 32'h0601_0005, 32'h0500_0010, rxl, 0, 1, 0), 106);
    // Release the ring while capturing into the full FIFO: simultaneous pop keeps it full, no drop.
    step(mk(0, IDLE, 32'h0601_0006, 32'h0601_0001, rxl, 0, 1, 0), 107);
    step(mk(0, IDLE, 32'h0601_0006, 32'h0601_0002, rxl, 0, 0, 0), 108);
    step(mk(0, IDLE, 32'h0601_0006, 32'h0601_0003, rxl, 0, 0, 0), 109);
    step(mk(0, IDLE, 32'h0601_0006, 32'h0601_0004, rxl, 0, 0, 0), 110);
    step(mk(0, IDLE, 32'h0601_0006, 32'h0601_0006, rxl, 0, 0, 0), 111);
    step(mk(0, IDLE, 32'h0601_0006, IDLE,          rxl, 0, 0, 0), 112);

    // Reset with a queued entry and transit in flight discards both.
    step(mk(0, 32'h0500_0020, 32'h0602_0001, 32'h0500_0020, rxl, 0, 0, 0), 200);
    step(mk(1, 32'h0500_0021, IDLE,          IDLE,          IDLE, 0, 0, 0), 201);
    step(mk(0, IDLE,          IDLE,          IDLE,          IDLE, 0, 0, 0), 202);
    step(mk(0, IDLE,          IDLE,          IDLE,          IDLE, 0, 0, 0), 203);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
